// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared load/store funct3 codes and widths for the MEM-stage access path
package dmem_access_ctrl_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t FNC_LB  = 3'b000;
  localparam funct3_t FNC_LH  = 3'b001;
  localparam funct3_t FNC_LW  = 3'b010;
  localparam funct3_t FNC_LBU = 3'b100;
  localparam funct3_t FNC_LHU = 3'b101;

  localparam int WORD_W = 32;

endpackage

// File: rtl/load_data_ext.sv
// rtl/load_data_ext.sv - selects the addressed byte/halfword of a read word and sign/zero extends it
module load_data_ext
  import dmem_access_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  funct3_t           func,
  input  logic [1:0]        byte_addr,
  output logic [WORD_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (byte_addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfword offset comes only from bit 1; misaligned halfwords fold down.
    half_sel = byte_addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (func)
      FNC_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FNC_LH:  result = {{16{half_sel[15]}}, half_sel};
      FNC_LW:  result = word;
      FNC_LBU: result = {24'd0, byte_sel};
      FNC_LHU: result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - single-outstanding load/store controller between MEM stage and data memory/MMIO
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic                    req_we_in,
  input  logic [ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [DATA_WIDTH-1:0]   req_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] req_wea_in,
  input  logic [2:0]              req_func_in,
  input  logic [4:0]              req_rd_in,
  output logic                    mem_req_valid_out,
  input  logic                    mem_req_ready_in,
  output logic [DATA_WIDTH/8-1:0] mem_we_out,
  output logic [ADDR_WIDTH-3:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  input  logic                    mem_resp_valid_in,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data_in,
  output logic                    resp_valid_out,
  output logic [DATA_WIDTH-1:0]   resp_data_out,
  output logic [4:0]              resp_rd_out,
  output logic                    stall_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              we_q;
  funct3_t           func_q;
  logic [1:0]        boff_q;
  logic [4:0]        rd_q;
  logic              start_issue;
  logic              issue_done;
  logic              resp_hit;
  logic [WORD_W-1:0] ext_data;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready_out = 1'b0;
    start_issue   = 1'b0;
    issue_done    = 1'b0;
    resp_hit      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_out = 1'b1;
        // A store with no enabled lanes is retired on the spot without a memory access.
        if (req_valid_in && (!req_we_in || (req_wea_in != '0))) begin
          start_issue = 1'b1;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready_in) begin
          issue_done = 1'b1;
          state_nxt  = we_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid_in) begin
          resp_hit  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall_out = (state != S_IDLE);

  load_data_ext u_ext (
    .word      (mem_resp_data_in),
    .func      (func_q),
    .byte_addr (boff_q),
    .result    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid_out <= 1'b0;
      mem_we_out        <= '0;
      mem_addr_out      <= '0;
      mem_wdata_out     <= '0;
      resp_valid_out    <= 1'b0;
      resp_data_out     <= '0;
      resp_rd_out       <= '0;
      we_q              <= 1'b0;
      func_q            <= '0;
      boff_q            <= '0;
      rd_q              <= '0;
    end else begin
      resp_valid_out <= resp_hit;
      if (start_issue) begin
        mem_req_valid_out <= 1'b1;
        mem_we_out        <= req_we_in ? req_wea_in : '0;
        mem_addr_out      <= req_addr_in[ADDR_WIDTH-1:2];
        mem_wdata_out     <= req_wdata_in;
        we_q              <= req_we_in;
        func_q            <= req_func_in;
        boff_q            <= req_addr_in[1:0];
        rd_q              <= req_rd_in;
      end else if (issue_done) begin
        mem_req_valid_out <= 1'b0;
        mem_we_out        <= '0;
      end
      if (resp_hit) begin
        resp_data_out <= ext_data;
        resp_rd_out   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed and randomized self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [3:0]  req_wea_in;
  logic [2:0]  req_func_in;
  logic [4:0]  req_rd_in;
  logic        mem_req_valid_out;
  logic        mem_req_ready_in;
  logic [3:0]  mem_we_out;
  logic [29:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic        mem_resp_valid_in;
  logic [31:0] mem_resp_data_in;
  logic        resp_valid_out;
  logic [31:0] resp_data_out;
  logic [4:0]  resp_rd_out;
  logic        stall_out;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] last_resp = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  dmem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_in      (req_valid_in),
    .req_ready_out     (req_ready_out),
    .req_we_in         (req_we_in),
    .req_addr_in       (req_addr_in),
    .req_wdata_in      (req_wdata_in),
    .req_wea_in        (req_wea_in),
    .req_func_in       (req_func_in),
    .req_rd_in         (req_rd_in),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_ready_in  (mem_req_ready_in),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
    .mem_resp_valid_in (mem_resp_valid_in),
    .mem_resp_data_in  (mem_resp_data_in),
    .resp_valid_out    (resp_valid_out),
    .resp_data_out     (resp_data_out),
    .resp_rd_out       (resp_rd_out),
    .stall_out         (stall_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_valid_out && mem_req_ready_in) hs_cnt <= hs_cnt + 1;
    if (resp_valid_out) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result from the extraction rules, done with shifts and signed arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] w, input logic [1:0] b);
    longint v;
    int sh;
    case (f)
      3'b000, 3'b100: begin
        sh = 8 * int'(b);
        v  = longint'((w >> sh) & 32'hFF);
        if (f == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        sh = (b >= 2) ? 16 : 0;
        v  = longint'((w >> sh) & 32'hFFFF);
        if (f == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    req_valid_in = 1'b0; req_we_in = 1'b0; req_addr_in = '0; req_wdata_in = '0;
    req_wea_in = '0; req_func_in = '0; req_rd_in = '0;
    mem_resp_valid_in = 1'b0; mem_resp_data_in = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wea, input int delay);
    int h0;
    int r0;
    h0 = hs_cnt; r0 = resp_cnt;
    chk("st_ready_before", 32'(req_ready_out), 32'd1);
    req_valid_in = 1'b1; req_we_in = 1'b1; req_addr_in = addr; req_wdata_in = wd; req_wea_in = wea;
    req_func_in = 3'($urandom); mem_req_ready_in = (delay == 0);
    @(negedge clk);
    req_valid_in = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk("st_valid", 32'(mem_req_valid_out), 32'd1);
      chk("st_addr", 32'(mem_addr_out), 32'(addr[31:2]));
      chk("st_wdata", mem_wdata_out, wd);
      chk("st_we", 32'(mem_we_out), 32'(wea));
      chk("st_stall", 32'(stall_out), 32'd1);
      chk("st_ready_busy", 32'(req_ready_out), 32'd0);
      @(negedge clk);
    end
    mem_req_ready_in = 1'b1;
    chk("st_valid_hs", 32'(mem_req_valid_out), 32'd1);
    chk("st_addr_hs", 32'(mem_addr_out), 32'(addr[31:2]));
    chk("st_we_hs", 32'(mem_we_out), 32'(wea));
    @(negedge clk);
    chk("st_valid_after", 32'(mem_req_valid_out), 32'd0);
    chk("st_we_after", 32'(mem_we_out), 32'd0);
    chk("st_ready_after", 32'(req_ready_out), 32'd1);
    chk("st_stall_after", 32'(stall_out), 32'd0);
    chk("st_one_hs", 32'(hs_cnt - h0), 32'd1);
    chk("st_no_resp", 32'(resp_cnt - r0), 32'd0);
    chk("st_resp_hold", resp_data_out, last_resp);
    chk("st_rd_hold", 32'(resp_rd_out), 32'(last_rd));
  endtask

  task automatic do_load(input logic [2:0] f, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] word, input int lat, input logic [31:0] exp);
    int h0;
    int r0;
    h0 = hs_cnt; r0 = resp_cnt;
    chk("ld_ready_before", 32'(req_ready_out), 32'd1);
    req_valid_in = 1'b1; req_we_in = 1'b0; req_addr_in = addr; req_wdata_in = $urandom;
    req_wea_in = 4'hF; req_func_in = f; req_rd_in = rd; mem_req_ready_in = 1'b1;
    @(negedge clk);
    req_valid_in = 1'b0;
    chk("ld_valid", 32'(mem_req_valid_out), 32'd1);
    chk("ld_we_zero", 32'(mem_we_out), 32'd0);
    chk("ld_addr", 32'(mem_addr_out), 32'(addr[31:2]));
    @(negedge clk);
    chk("ld_valid_drop", 32'(mem_req_valid_out), 32'd0);
    for (int i = 1; i < lat; i++) begin
      chk("ld_wait_stall", 32'(stall_out), 32'd1);
      chk("ld_wait_noresp", 32'(resp_valid_out), 32'd0);
      @(negedge clk);
    end
    mem_resp_valid_in = 1'b1; mem_resp_data_in = word;
    @(negedge clk);
    mem_resp_valid_in = 1'b0; mem_resp_data_in = $urandom;
    chk("ld_resp_valid", 32'(resp_valid_out), 32'd1);
    chk("ld_resp_data", resp_data_out, exp);
    chk("ld_resp_rd", 32'(resp_rd_out), 32'(rd));
    chk("ld_resp_stall", 32'(stall_out), 32'd1);
    @(negedge clk);
    chk("ld_pulse_end", 32'(resp_valid_out), 32'd0);
    chk("ld_data_hold", resp_data_out, exp);
    chk("ld_ready_after", 32'(req_ready_out), 32'd1);
    chk("ld_one_pulse", 32'(resp_cnt - r0), 32'd1);
    chk("ld_one_hs", 32'(hs_cnt - h0), 32'd1);
    last_resp = exp; last_rd = rd;
  endtask

  typedef struct { logic [2:0] f; logic [1:0] b; logic [31:0] exp; } ld_case_t;
  ld_case_t cases[5];
  logic [2:0] rfunc;
  logic [31:0] raddr;
  logic [31:0] rword;
  int h0;
  int r0;

  initial begin
    idle_inputs();
    mem_req_ready_in = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready_out), 32'd1);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid_out), 32'd0);
    chk("rst_mem_we", 32'(mem_we_out), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_out), 32'd0);
    chk("rst_mem_wdata", mem_wdata_out, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_out), 32'd0);
    chk("rst_resp_data", resp_data_out, 32'd0);
    chk("rst_resp_rd", 32'(resp_rd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_store(32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 0);
    do_store(32'h0000_2008, 32'h1234_5678, 4'b0011, 3);

    cases[0] = '{3'b000, 2'd1, 32'hFFFF_FFF0};
    cases[1] = '{3'b100, 2'd3, 32'h0000_0080};
    cases[2] = '{3'b001, 2'd3, 32'hFFFF_8070};
    cases[3] = '{3'b101, 2'd0, 32'h0000_F0FF};
    cases[4] = '{3'b010, 2'd2, 32'h8070_F0FF};
    foreach (cases[i])
      do_load(cases[i].f, 32'h0000_3000 | 32'(cases[i].b), 5'(i + 3), 32'h8070_F0FF, 1, cases[i].exp);

    do_load(3'b010, 32'h0000_4010, 5'd17, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);

    // Reset while a load is waiting on memory; the late response must vanish.
    r0 = resp_cnt;
    req_valid_in = 1'b1; req_we_in = 1'b0; req_addr_in = 32'h0000_5000; req_func_in = 3'b010;
    req_rd_in = 5'd9; mem_req_ready_in = 1'b1;
    @(negedge clk);
    req_valid_in = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", 32'(stall_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_resp_valid_in = 1'b1; mem_resp_data_in = 32'h1111_2222;
    @(negedge clk);
    mem_resp_valid_in = 1'b0;
    chk("rw_ready", 32'(req_ready_out), 32'd1);
    chk("rw_stall", 32'(stall_out), 32'd0);
    chk("rw_mem_valid", 32'(mem_req_valid_out), 32'd0);
    repeat (3) @(negedge clk);
    chk("rw_no_pulse", 32'(resp_cnt - r0), 32'd0);
    chk("rw_resp_data", resp_data_out, 32'd0);
    last_resp = 32'd0; last_rd = 5'd0;

    // Store with no enabled lanes retires without touching memory.
    h0 = hs_cnt;
    req_valid_in = 1'b1; req_we_in = 1'b1; req_addr_in = 32'h0000_6000; req_wdata_in = 32'hAAAA_5555;
    req_wea_in = 4'b0000;
    @(negedge clk);
    req_valid_in = 1'b0;
    chk("z_no_valid", 32'(mem_req_valid_out), 32'd0);
    chk("z_ready", 32'(req_ready_out), 32'd1);
    chk("z_stall", 32'(stall_out), 32'd0);
    do_load(3'b100, 32'h0000_6001, 5'd5, 32'h0000_AB00, 2, 32'h0000_00AB);
    chk("z_hs_count", 32'(hs_cnt - h0), 32'd1);

    for (int n = 0; n < 40; n++) begin
      raddr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_store(raddr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
      end else begin
        rfunc = 3'($urandom);
        rword = $urandom;
        do_load(rfunc, raddr, 5'($urandom), rword, $urandom_range(1, 4),
                ref_load(rfunc, rword, raddr[1:0]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
